// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32IM instruction cache: FSM state encoding and
// geometry helpers (tag width, line count, data-array address width).
// No ports; imported by the cache top with import rv32im_pkg::*.
package rv32im_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        READ   = 3'd2,
        COMMIT = 3'd3,
        REPLAY = 3'd4
    } icache_state_t;

    // Tag holds the address bits above set index and line offset, below the
    // ignored upper region.
    function automatic int tag_bits(input int xlen, input int unused_bits,
                                    input int line_len, input int set_bits);
        return xlen - unused_bits - line_len - 2 - set_bits;
    endfunction

    // Number of cache lines across all sets and ways.
    function automatic int line_count(input int set_bits, input int ways);
        return (1 << set_bits) * ways;
    endfunction

    // Way-select register width; a direct-mapped cache still needs one bit.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Data array word address width: set, way and word-in-line.
    function automatic int bram_addr_bits(input int set_bits, input int line_len,
                                          input int ways);
        return $clog2(line_count(set_bits, ways)) + line_len;
    endfunction

endpackage

// File: rtl/bram_dual_re.sv
// Simple dual-port block RAM: one write port, one registered read port with enable.
// Latency: read data valid the cycle after re; no backpressure.
// Ports: clk, we/waddr/wdata (write), re/raddr (read request), rdata (registered read).
module bram_dual_re #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rv32im_icache_assoc.sv
// Set-associative instruction cache with Wishbone line refill and round-robin replacement.
// Latency: hit -> valid_o 1 cycle after req_i; miss -> valid_o 3 cycles after the last ack.
// Backpressure: req_i ignored while busy_o; bus owned only between ctrl_grant_i and the last ack/err.
// Ports: clk_i/reset_i; fetch req_i/addr_i -> instr_o/valid_o/busy_o/misaligned_o/fetch_err_o;
// arbitration ctrl_req_o/ctrl_grant_i; Wishbone master master_dat_i/ack_i/err_i/adr_o/cyc_o/stb_o/sel_o.
// Optional RV32IM_ICACHE_FLUSH_EN adds flush_i (whole-cache invalidate, deferred while busy).
module rv32im_icache_assoc
    import rv32im_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ILEN             = 32,
    parameter int LINE_LEN         = 4,
    parameter int SET_BITS         = 2,
    parameter int WAYS             = 2,
    parameter int UNUSED_ADDR_BITS = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
`ifdef RV32IM_ICACHE_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic              req_i,
    input  logic [XLEN-1:0]   addr_i,
    output logic [ILEN-1:0]   instr_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              misaligned_o,
    output logic              fetch_err_o,
    output logic              ctrl_req_o,
    input  logic              ctrl_grant_i,
    input  logic [XLEN-1:0]   master_dat_i,
    input  logic              ack_i,
    input  logic              err_i,
    output logic [XLEN-3:0]   adr_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [3:0]        sel_o
);

    localparam int TAG_W      = tag_bits(XLEN, UNUSED_ADDR_BITS, LINE_LEN, SET_BITS);
    localparam int NSETS      = 1 << SET_BITS;
    localparam int LINE_WORDS = 1 << LINE_LEN;
    localparam int WAY_W      = way_bits(WAYS);
    localparam int AW         = bram_addr_bits(SET_BITS, LINE_LEN, WAYS);

    icache_state_t state_q, state_d;

    logic [TAG_W-1:0]   tag_q [NSETS][WAYS];
    logic [WAYS-1:0]    vld_q [NSETS];
    logic [WAY_W-1:0]   rr_q  [NSETS];

    logic [XLEN-1:0]    addr_q;
    logic [WAY_W-1:0]   victim_q;
    logic [LINE_LEN:0]  cnt_q;
    logic               busy_q, ctrl_req_q, cyc_q;
    logic               valid_q, mis_q, ferr_q;

    // Lookup runs on the incoming address in IDLE and on the latched miss
    // address in REPLAY, so one comparator bank serves both.
    logic [XLEN-1:0]     look_addr;
    logic [SET_BITS-1:0] set_l, set_q;
    logic [TAG_W-1:0]    tag_l;
    logic [LINE_LEN-1:0] word_l;
    logic                hit;
    logic [WAY_W-1:0]    hit_way, vic, rr_cur, rr_next;
    logic                last;

    logic latch, bram_re, fill_we, commit, go_valid, go_mis, go_err;
    logic flush_now;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [XLEN-1:0] rdata;
    logic            unused_bits;

    assign look_addr = (state_q == REPLAY) ? addr_q : addr_i;
    assign set_l     = look_addr[LINE_LEN+2 +: SET_BITS];
    assign tag_l     = look_addr[XLEN-1-UNUSED_ADDR_BITS -: TAG_W];
    assign word_l    = look_addr[2 +: LINE_LEN];
    assign set_q     = addr_q[LINE_LEN+2 +: SET_BITS];
    assign last      = (cnt_q == (LINE_LEN+1)'(LINE_WORDS-1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld_q[set_l][w] && (tag_q[set_l][w] == tag_l)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; descending scan lets the lowest index overwrite.
    always_comb begin
        vic = rr_q[set_l];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_q[set_l][w]) begin
                vic = WAY_W'(w);
            end
        end
    end

    assign rr_cur  = rr_q[set_q];
    assign rr_next = (rr_cur == WAY_W'(WAYS - 1)) ? '0 : rr_cur + 1'b1;

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        bram_re  = 1'b0;
        fill_we  = 1'b0;
        commit   = 1'b0;
        go_valid = 1'b0;
        go_mis   = 1'b0;
        go_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (addr_i[1:0] != 2'b00) begin
                        go_mis = 1'b1;
                    end else if (hit) begin
                        bram_re  = 1'b1;
                        go_valid = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (ctrl_grant_i) begin
                    state_d = READ;
                end
            end
            READ: begin
                // err_i dominates a simultaneous ack_i.
                if (err_i) begin
                    go_err  = 1'b1;
                    state_d = IDLE;
                end else if (ack_i) begin
                    fill_we = 1'b1;
                    if (last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = REPLAY;
            end
            REPLAY: begin
                bram_re  = 1'b1;
                go_valid = hit;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            victim_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ctrl_req_q <= 1'b0;
            cyc_q      <= 1'b0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= go_valid;
            mis_q   <= go_mis;
            ferr_q  <= go_err;
            if (latch) begin
                addr_q     <= addr_i;
                victim_q   <= vic;
                cnt_q      <= '0;
                busy_q     <= 1'b1;
                ctrl_req_q <= 1'b1;
            end
            if (state_q == ARB && ctrl_grant_i) begin
                cyc_q <= 1'b1;
            end
            if (fill_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (go_err || (fill_we && last)) begin
                cyc_q      <= 1'b0;
                ctrl_req_q <= 1'b0;
            end
            if (go_err || state_q == REPLAY) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The victim is invalidated as soon as its refill starts: its data words
    // are overwritten during READ, so an aborted fill must not leave the old
    // tag pointing at a half-replaced line.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < NSETS; s++) begin
                vld_q[s] <= '0;
                rr_q[s]  <= '0;
            end
        end else begin
            if (flush_now) begin
                for (int s = 0; s < NSETS; s++) begin
                    vld_q[s] <= '0;
                end
            end else if (latch) begin
                vld_q[set_l][vic] <= 1'b0;
            end else if (commit) begin
                vld_q[set_q][victim_q] <= 1'b1;
            end
            if (commit) begin
                rr_q[set_q] <= rr_next;
            end
        end
    end

    // Tags need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk_i) begin
        if (commit) begin
            tag_q[set_q][victim_q] <= addr_q[XLEN-1-UNUSED_ADDR_BITS -: TAG_W];
        end
    end

`ifdef RV32IM_ICACHE_FLUSH_EN
    logic flush_pend_q;
    logic flush_req;

    // A flush seen while busy is parked and applied on the cycle the FSM
    // returns to IDLE, which also drops the line just filled.
    assign flush_req = flush_i || flush_pend_q;
    assign flush_now = flush_req && (state_q == IDLE || state_d == IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_req && !flush_now;
        end
    end
`else
    assign flush_now = 1'b0;
`endif

    assign rd_addr = AW'((int'(set_l) * WAYS + int'(hit_way)) * LINE_WORDS + int'(word_l));
    assign wr_addr = AW'((int'(set_q) * WAYS + int'(victim_q)) * LINE_WORDS
                         + int'(cnt_q[LINE_LEN-1:0]));

    bram_dual_re #(
        .DATA_W (XLEN),
        .ADDR_W (AW)
    ) u_data (
        .clk   (clk_i),
        .we    (fill_we),
        .waddr (wr_addr),
        .wdata (master_dat_i),
        .re    (bram_re),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    // RAM output has no reset; gating with valid gives a clean zero out of reset.
    assign instr_o      = valid_q ? rdata[ILEN-1:0] : '0;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign misaligned_o = mis_q;
    assign fetch_err_o  = ferr_q;
    assign ctrl_req_o   = ctrl_req_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign sel_o        = 4'b1111;
    assign adr_o        = {addr_q[XLEN-1:LINE_LEN+2], cnt_q[LINE_LEN-1:0]};

    assign unused_bits  = ^addr_q[1:0];

endmodule

// File: tb/tb_rv32im_icache_assoc.sv
// Scoreboard bench for rv32im_icache_assoc: directed fetches, a Wishbone
// memory model, and a monitor comparing every valid/misaligned/error output.
module tb_rv32im_icache_assoc;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
`ifdef RV32IM_ICACHE_FLUSH_EN
    logic        flush_i = 1'b0;
`endif
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] instr_o;
    logic        valid_o, busy_o, misaligned_o, fetch_err_o, ctrl_req_o;
    logic        ctrl_grant_i = 1'b0;
    logic [31:0] master_dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [29:0] adr_o;
    logic        cyc_o, stb_o;
    logic [3:0]  sel_o;

    rv32im_icache_assoc dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
`ifdef RV32IM_ICACHE_FLUSH_EN
        .flush_i      (flush_i),
`endif
        .req_i        (req_i),
        .addr_i       (addr_i),
        .instr_o      (instr_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .misaligned_o (misaligned_o),
        .fetch_err_o  (fetch_err_o),
        .ctrl_req_o   (ctrl_req_o),
        .ctrl_grant_i (ctrl_grant_i),
        .master_dat_i (master_dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .adr_o        (adr_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .sel_o        (sel_o)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 = valid_o, 1 = misaligned_o, 2 = fetch_err_o
    // when_sel: 0 = absolute cycle, 1 = last ack + 3, 2 = err cycle + 1
    typedef struct {
        int          kind;
        logic [31:0] instr;
        int          when_sel;
        int          when_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] adr_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc_n = 0;
    int          last_ack_cyc = 0;
    int          err_cyc = 0;
    int          err_word = -1;

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Wishbone slave + arbiter: grants one cycle after request, acks every
    // strobed cycle, optionally raises err_i (with ack_i) on one word index.
    always @(negedge clk_i) begin
        ack_i        = 1'b0;
        err_i        = 1'b0;
        master_dat_i = '0;
        ctrl_grant_i = ctrl_req_o;
        if (!reset_i && cyc_o && stb_o) begin
            master_dat_i = mem_word(adr_o);
            ack_i        = 1'b1;
            adr_log.push_back(adr_o);
            if (err_word >= 0 && adr_o[3:0] == 4'(err_word)) begin
                err_i   = 1'b1;
                err_cyc = cyc_n;
            end else begin
                last_ack_cyc = cyc_n;
            end
        end
    end

    // Monitor: every output event pops one expectation.
    always @(negedge clk_i) begin
        int   kind;
        int   want;
        exp_t e;
        if (!reset_i) begin
            if (cyc_o || stb_o) begin
                check("wb_cyc_eq_stb_sel", 32'({cyc_o == stb_o, sel_o}), 32'h1F);
            end
            if (valid_o || misaligned_o || fetch_err_o) begin
                kind = valid_o ? 0 : (misaligned_o ? 1 : 2);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output kind=%0d expected=none (t=%0t)", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind", 32'(kind), 32'(e.kind));
                    if (e.kind == 0) begin
                        check("instr", instr_o, e.instr);
                    end
                    want = (e.when_sel == 1) ? last_ack_cyc + 3 :
                           (e.when_sel == 2) ? err_cyc + 1 : e.when_cyc;
                    check("out_cycle", 32'(cyc_n), 32'(want));
                end
            end
        end
    end

    // outcome: 0 valid, 1 misaligned, 2 bus error, -1 none (aborted by reset)
    task automatic issue(input logic [31:0] a, input bit exp_hit, input int outcome);
        exp_t e;
        int   rc;
        bit   exp_busy;
        @(negedge clk_i);
        req_i  = 1'b1;
        addr_i = a;
        rc     = cyc_n;
        if (outcome >= 0) begin
            e.kind     = outcome;
            e.instr    = mem_word(a[31:2]);
            e.when_sel = (exp_hit || outcome == 1) ? 0 : (outcome == 2 ? 2 : 1);
            e.when_cyc = rc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        req_i    = 1'b0;
        exp_busy = !exp_hit && outcome != 1;
        check("busy_after_req", 32'(busy_o), 32'(exp_busy));
        if (!exp_busy) begin
            check("no_bus_req_c1", 32'({ctrl_req_o, cyc_o}), 32'h0);
            @(negedge clk_i);
            check("no_bus_req_c2", 32'({ctrl_req_o, cyc_o}), 32'h0);
        end else if (outcome >= 0) begin
            for (int i = 0; i < 400 && busy_o; i++) @(negedge clk_i);
            check("fill_done_busy_low", 32'(busy_o), 32'h0);
            @(negedge clk_i);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        check("reset_ctrl_outputs",
              32'({valid_o, busy_o, misaligned_o, fetch_err_o, ctrl_req_o, cyc_o, stb_o}), 32'h0);
        check("reset_instr", instr_o, 32'h0);
        reset_i = 1'b0;

        // Cold miss at 0x100: 16 words from 0x40..0x4F, valid three cycles after last ack.
        adr_log.delete();
        issue(32'h100, 1'b0, 0);
        check("cold_fill_len", 32'(adr_log.size()), 32'd16);
        if (adr_log.size() == 16) begin
            for (int i = 0; i < 16; i++) check("cold_fill_adr", 32'(adr_log[i]), 32'h40 + 32'(i));
        end

        // Hit on the last word of the same line.
        issue(32'h13C, 1'b1, 0);

        // Misaligned: pulse only.
        issue(32'h102, 1'b0, 1);

        // Replacement in set 0 (line 0x100 is way 0, pointer at 1).
        issue(32'h000, 1'b0, 0);   // invalid way 1
        issue(32'h400, 1'b0, 0);   // pointer 0 -> evicts 0x100
        issue(32'h800, 1'b0, 0);   // pointer 1 -> evicts 0x000
        issue(32'h404, 1'b1, 0);   // 0x400 line still resident
        issue(32'h000, 1'b0, 0);   // 0x000 was evicted

        // Bus error on the 5th word, then a repeat request misses again.
        err_word = 4;
        adr_log.delete();
        issue(32'h200, 1'b0, 2);
        check("err_words_on_bus", 32'(adr_log.size()), 32'd5);
        err_word = -1;
        issue(32'h200, 1'b0, 0);
        issue(32'h23C, 1'b1, 0);

        // Reset after the 3rd ack of a fill.
        issue(32'h100, 1'b0, -1);
        n = 0;
        for (int i = 0; i < 100 && n < 3; i++) begin
            @(posedge clk_i);
            if (ack_i && !err_i) n++;
        end
        check("acks_before_reset", 32'(n), 32'd3);
        #2 reset_i = 1'b1;
        #1 check("reset_midfill_bus", 32'({cyc_o, stb_o, ctrl_req_o, busy_o}), 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        issue(32'h100, 1'b0, 0);   // nothing was committed: misses
        issue(32'h200, 1'b0, 0);   // reset cleared all lines

`ifdef RV32IM_ICACHE_FLUSH_EN
        issue(32'h100, 1'b1, 0);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        issue(32'h100, 1'b0, 0);
`endif

        repeat (5) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d expected=finish", cyc_n);
        $fatal(1);
    end

endmodule
